// File: rtl/silife_pkg.sv
// Shared SiLife definitions: statistics FSM states and result field widths.
package silife_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int SIG_BITS       = 16;
  localparam int STILL_CNT_BITS = 8;

endpackage

// File: rtl/silife_popcount.sv
// Combinational population count of one grid row.
module silife_popcount #(
  parameter  int WIDTH = 32,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] bits,
  output logic [CW-1:0]    count
);

  always_comb begin
    count = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/silife_stats.sv
// Per-generation grid statistics: population, rotating XOR signature and
// still-life detection, gathered by scanning rows through the grid read port.
module silife_stats
  import silife_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int HEIGHT   = 32,
  localparam int ROW_BITS = $clog2(HEIGHT),
  localparam int POP_BITS = $clog2(WIDTH * HEIGHT + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_enable,
  input  logic                      i_step,
  output logic [ROW_BITS-1:0]       o_row_select,
  input  logic [WIDTH-1:0]          i_cells,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [POP_BITS-1:0]       o_population,
  output logic [SIG_BITS-1:0]       o_signature,
  output logic                      o_still,
  output logic [STILL_CNT_BITS-1:0] o_still_count,
  output logic [31:0]               o_gen_count
);

  localparam int PC_BITS  = $clog2(WIDTH + 1);
  localparam int PAD_W    = ((WIDTH + 15) / 16) * 16;
  localparam logic [ROW_BITS-1:0]       LAST_ROW  = ROW_BITS'(HEIGHT - 1);
  localparam logic [STILL_CNT_BITS-1:0] STILL_MAX = '1;

  function automatic logic [15:0] fold16(input logic [WIDTH-1:0] row);
    logic [PAD_W-1:0] padded;
    logic [15:0]      f;
    padded = PAD_W'(row);
    f      = '0;
    for (int unsigned s = 0; s < PAD_W / 16; s++) begin
      f = f ^ padded[s*16 +: 16];
    end
    return f;
  endfunction

  state_t                state, state_nx;
  logic [ROW_BITS-1:0]   row_nx;
  logic                  pending;
  logic                  row_valid;
  logic                  have_prev;
  logic [POP_BITS-1:0]   pop_acc, pop_sum;
  logic [SIG_BITS-1:0]   sig_acc, sig_sum;
  logic [PC_BITS-1:0]    row_pc;
  logic                  accept, go, start, publish, still_nx;

  silife_popcount #(.WIDTH(WIDTH)) u_popcount (
    .bits  (i_cells),
    .count (row_pc)
  );

  assign accept  = i_enable & i_step;
  assign go      = i_enable & (i_step | pending);
  assign publish = (state == DRAIN);

  // The last row arrives during DRAIN, so results are published from the
  // accumulators plus the row being sampled on the same edge.
  assign pop_sum  = pop_acc + POP_BITS'(row_pc);
  assign sig_sum  = {sig_acc[SIG_BITS-2:0], sig_acc[SIG_BITS-1]} ^ fold16(i_cells);
  assign still_nx = have_prev && (pop_sum == o_population) && (sig_sum == o_signature);

  always_comb begin
    state_nx = state;
    row_nx   = '0;
    case (state)
      IDLE:  if (go) state_nx = SCAN;
      SCAN: begin
        if (o_row_select == LAST_ROW) state_nx = DRAIN;
        else                          row_nx   = o_row_select + 1'b1;
      end
      DRAIN: state_nx = go ? SCAN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign start = (state_nx == SCAN) && (state != SCAN);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      o_row_select  <= '0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      row_valid     <= 1'b0;
      pending       <= 1'b0;
      have_prev     <= 1'b0;
      pop_acc       <= '0;
      sig_acc       <= '0;
      o_population  <= '0;
      o_signature   <= '0;
      o_still       <= 1'b0;
      o_still_count <= '0;
      o_gen_count   <= '0;
    end else begin
      state        <= state_nx;
      o_row_select <= row_nx;
      o_busy       <= (state_nx != IDLE);
      o_done       <= publish;
      row_valid    <= (state == SCAN);

      if (accept) o_gen_count <= o_gen_count + 32'd1;

      if (!i_enable || start)           pending <= 1'b0;
      else if (i_step && state != IDLE) pending <= 1'b1;

      if (start) begin
        pop_acc <= '0;
        sig_acc <= '0;
      end else if (row_valid) begin
        pop_acc <= pop_sum;
        sig_acc <= sig_sum;
      end

      if (publish) begin
        o_population <= pop_sum;
        o_signature  <= sig_sum;
        o_still      <= still_nx;
        have_prev    <= 1'b1;
        if (!still_nx)                     o_still_count <= '0;
        else if (o_still_count != STILL_MAX) o_still_count <= o_still_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_silife_stats.sv
// Directed self-checking bench for silife_stats with a registered-read grid model.
module tb_silife_stats;

  localparam int W = 32;
  localparam int H = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_enable;
  logic        i_step;
  logic [4:0]  o_row_select;
  logic [31:0] i_cells;
  logic        o_busy;
  logic        o_done;
  logic [10:0] o_population;
  logic [15:0] o_signature;
  logic        o_still;
  logic [7:0]  o_still_count;
  logic [31:0] o_gen_count;

  logic [31:0] grid [H];
  int checks   = 0;
  int failures = 0;
  int exp_gen  = 0;

  silife_stats #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk           (clk),
    .reset         (reset),
    .i_enable      (i_enable),
    .i_step        (i_step),
    .o_row_select  (o_row_select),
    .i_cells       (i_cells),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_population  (o_population),
    .o_signature   (o_signature),
    .o_still       (o_still),
    .o_still_count (o_still_count),
    .o_gen_count   (o_gen_count)
  );

  always #5 clk = ~clk;

  // Grid read port: data for the addressed row appears one cycle later.
  always @(posedge clk) i_cells <= grid[o_row_select];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_grid();
    for (int r = 0; r < H; r++) grid[r] = '0;
  endtask

  task automatic run_scan(input string tag, input int exp_pop, input logic [15:0] exp_sig,
                          input logic exp_still, input int exp_sc);
    int n;
    i_step = 1'b1;
    @(posedge clk); #1;
    i_step = 1'b0;
    exp_gen++;
    chk({tag, "_busy"}, o_busy, 1);
    n = 0;
    while (n < 100) begin
      @(posedge clk); #1;
      n++;
      if (o_done) break;
    end
    chk({tag, "_lat"},   n, H + 1);
    chk({tag, "_pop"},   o_population, exp_pop);
    chk({tag, "_sig"},   o_signature, exp_sig);
    chk({tag, "_still"}, o_still, exp_still);
    chk({tag, "_scnt"},  o_still_count, exp_sc);
    chk({tag, "_gen"},   o_gen_count, exp_gen);
    @(posedge clk); #1;
    chk({tag, "_pulse"}, o_done, 0);
    chk({tag, "_idle"},  o_busy, 0);
  endtask

  initial begin
    int t, first, extra, n;
    reset = 1'b1; i_enable = 1'b1; i_step = 1'b0;
    clear_grid();
    #2;
    chk("rst_row", o_row_select, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_pop", o_population, 0);
    chk("rst_sig", o_signature, 0);
    chk("rst_still", o_still, 0);
    chk("rst_scnt", o_still_count, 0);
    chk("rst_gen", o_gen_count, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    run_scan("empty1", 0, 16'h0000, 0, 0);
    run_scan("empty2", 0, 16'h0000, 1, 1);

    for (int r = 0; r < H; r++) grid[r] = '1;
    run_scan("full", 1024, 16'h0000, 0, 0);

    clear_grid();
    grid[5] = 32'h18; grid[6] = 32'h18;
    run_scan("block1", 4, 16'h5000, 0, 0);
    run_scan("block2", 4, 16'h5000, 1, 1);
    run_scan("block3", 4, 16'h5000, 1, 2);

    // Row rotation and column position alias, so both blinker phases hash alike.
    clear_grid();
    grid[10] = 32'h1C;
    run_scan("blinkh", 3, 16'h0380, 0, 0);
    clear_grid();
    grid[9] = 32'h08; grid[10] = 32'h08; grid[11] = 32'h08;
    run_scan("blinkv", 3, 16'h0380, 1, 1);

    clear_grid();
    grid[0] = 32'h1;
    run_scan("cell0", 1, 16'h8000, 0, 0);
    clear_grid();
    grid[1] = 32'h1;
    run_scan("cell1", 1, 16'h4000, 0, 0);

    // Steps arriving mid-scan coalesce into one follow-on scan.
    clear_grid();
    i_step = 1'b1;
    @(posedge clk); #1;
    i_step = 1'b0;
    exp_gen++;
    t = 0;
    repeat (2) begin @(posedge clk); #1; t++; end
    for (int k = 0; k < 3; k++) begin
      i_step = 1'b1;
      @(posedge clk); #1; t++;
      i_step = 1'b0;
      exp_gen++;
      @(posedge clk); #1; t++;
    end
    while (!o_done && t < 200) begin @(posedge clk); #1; t++; end
    first = t;
    chk("multi_lat1", first, H + 1);
    chk("multi_still1", o_still, 0);
    chk("multi_busy", o_busy, 1);
    @(posedge clk); #1; t++;
    while (!o_done && t < 300) begin @(posedge clk); #1; t++; end
    chk("multi_gap", t - first, H + 1);
    chk("multi_still2", o_still, 1);
    chk("multi_scnt2", o_still_count, 1);
    extra = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (o_done) extra++;
    end
    chk("multi_extra", extra, 0);
    chk("multi_gen", o_gen_count, exp_gen);

    // Asynchronous reset in the middle of a scan.
    i_step = 1'b1;
    @(posedge clk); #1;
    i_step = 1'b0;
    n = 0;
    while (o_row_select != 5'd10 && n < 50) begin @(posedge clk); #1; n++; end
    chk("mid_row10", o_row_select, 10);
    reset = 1'b1;
    #1;
    chk("mid_rst_row", o_row_select, 0);
    chk("mid_rst_busy", o_busy, 0);
    chk("mid_rst_pop", o_population, 0);
    chk("mid_rst_still", o_still, 0);
    chk("mid_rst_scnt", o_still_count, 0);
    chk("mid_rst_gen", o_gen_count, 0);
    exp_gen = 0;
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1;
    run_scan("post_rst", 0, 16'h0000, 0, 0);

    i_enable = 1'b0;
    extra = 0;
    repeat (3) begin
      i_step = 1'b1;
      @(posedge clk); #1;
      i_step = 1'b0;
      if (o_busy) extra++;
      @(posedge clk); #1;
      if (o_busy) extra++;
    end
    repeat (5) begin @(posedge clk); #1; if (o_busy || o_done) extra++; end
    chk("dis_noscan", extra, 0);
    chk("dis_gen", o_gen_count, exp_gen);
    i_enable = 1'b1;

    for (int i = 1; i <= 300; i++) begin
      run_scan("sat", 0, 16'h0000, 1, (i > 255) ? 255 : i);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
